// File: rtl/mem_bus_master.sv
// mem_bus_master
// Initiator on the shared tristate code/data memory bus. It turns a
// request/ready handshake into a single or burst read or write of
// req_len+1 consecutive words, then waits idle for the next request.
//
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (accepted only while idle)
//   req_write, req_addr, req_len  burst direction, first address, words minus one
//   wr_valid/wr_ready, wr_data    write-word handshake, one word per beat
//   rd_valid, rd_data             one-cycle pulse per returned read word
//   busy                          burst in progress
//   mem_data                      shared bus, driven only during a write beat
//   mem_address, mem_write        registered bus address and write strobe
module mem_bus_master #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ     = 2'd1,
        WR_WAIT  = 2'd2,
        WR_DRIVE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [LEN_W-1:0]  count_reg,    count_next;
    logic [DATA_W-1:0] wdata_reg,    wdata_next;
    logic              write_reg,    write_next;
    logic              rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0] rd_data_reg,  rd_data_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            wdata_reg    <= '0;
            write_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            wdata_reg    <= wdata_next;
            write_reg    <= write_next;
            rd_valid_reg <= rd_valid_next;
            rd_data_reg  <= rd_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        wdata_next    = wdata_reg;
        write_next    = 1'b0;        // strobe lasts exactly one beat
        rd_valid_next = 1'b0;        // pulse only after a READ capture
        rd_data_next  = rd_data_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    count_next = req_len;
                    state_next = req_write ? WR_WAIT : READ;
                end
            end
            READ: begin
                // Responder returns data combinationally for mem_address.
                rd_data_next  = mem_data;
                rd_valid_next = 1'b1;
                addr_next     = addr_reg + ADDR_ONE;
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - LEN_ONE;
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    wdata_next = wr_data;
                    write_next = 1'b1;
                    state_next = WR_DRIVE;
                end
            end
            WR_DRIVE: begin
                // Responder samples the word on this edge; advance afterwards.
                addr_next = addr_reg + ADDR_ONE;
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - LEN_ONE;
                    state_next = WR_WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready   = (state_reg == IDLE);
    assign wr_ready    = (state_reg == WR_WAIT);
    assign busy        = (state_reg != IDLE);
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
    assign mem_address = addr_reg;
    assign mem_write   = write_reg;

    // Drive enable shares the mem_write flop, so the bus is released the
    // moment the strobe drops (including an asynchronous reset mid-beat).
    assign mem_data = write_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule
